// File: rtl/unified_mem_arbiter_pkg.sv
// Shared encodings for the unified memory arbiter: access sizes, port owners and FSM states.
package unified_mem_arbiter_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic { OWNER_IF = 1'b0, OWNER_D = 1'b1 } owner_e;
  typedef enum logic { ST_IDLE = 1'b0, ST_BUSY = 1'b1 } arb_state_e;

  // funct3 size 11 has no RV32I meaning; the memory only ever sees a full word for it.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    case (size)
      SIZE_B:  return SIZE_B;
      SIZE_H:  return SIZE_H;
      default: return SIZE_W;
    endcase
  endfunction

endpackage

// File: rtl/unified_mem_arbiter_starve_ctr.sv
// Saturating count of consecutive data wins over a waiting fetch; force_if hands the next slot to IF.
module arb_starve_ctr
  import unified_mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic if_gnt,
  input  logic d_gnt,
  output logic force_if
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] starve_cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_reg <= '0;
    end else if (if_gnt || !if_req) begin
      starve_cnt_reg <= '0;
    end else if (d_gnt && (starve_cnt_reg != CNT_MAX)) begin
      starve_cnt_reg <= starve_cnt_reg + 1'b1;
    end
  end

  assign force_if = (starve_cnt_reg == CNT_MAX);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port unified memory between instruction fetch and the data port,
// tracking the owner through a fixed read latency and steering the response back.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  arb_state_e       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  owner_e           owner_reg, owner_next;
  logic             we_reg, we_next;
  logic             resp_cycle;
  logic             can_grant;
  logic             force_if;

  // The response cycle doubles as an issue slot, so accesses can run back to back.
  assign resp_cycle = (state_reg == ST_BUSY) && (cnt_reg == CNT_LAST);
  assign can_grant  = rst && ((state_reg == ST_IDLE) || resp_cycle);

  arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk     (clk),
    .rst     (rst),
    .if_req  (if_req),
    .if_gnt  (if_gnt),
    .d_gnt   (d_gnt),
    .force_if(force_if)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      owner_reg <= OWNER_IF;
      we_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      owner_reg <= owner_next;
      we_reg    <= we_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    owner_next = owner_reg;
    we_next    = we_reg;
    if_gnt     = 1'b0;
    d_gnt      = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_size   = SIZE_W;
    mem_addr   = if_addr;
    mem_wdata  = d_wdata;

    // Data wins unless IF has been passed over STARVE_MAX times in a row.
    if (can_grant) begin
      if (if_req && (!d_req || force_if)) begin
        if_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end

    if (d_gnt) begin
      mem_we   = d_we;
      mem_size = norm_size(d_size);
      mem_addr = d_addr;
    end
    mem_en = if_gnt || d_gnt;

    if (mem_en) begin
      state_next = ST_BUSY;
      cnt_next   = '0;
      owner_next = d_gnt ? OWNER_D : OWNER_IF;
      we_next    = d_gnt && d_we;
    end else if (state_reg == ST_BUSY) begin
      if (resp_cycle) begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  assign if_stall  = if_req && !if_gnt;
  assign if_rvalid = resp_cycle && (owner_reg == OWNER_IF);
  assign d_rvalid  = resp_cycle && (owner_reg == OWNER_D);
  assign if_rdata  = if_rvalid ? mem_rdata : 32'd0;
  assign d_rdata   = (d_rvalid && !we_reg) ? mem_rdata : 32'd0;

endmodule
